// File: rtl/cpu_types_pkg.sv
// Shared CPU types and branch-predictor constants.
package cpu_types_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned BTB_TAG_BASE = 2;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t PC_INCR = 32'd4;

  // Weak counter state of the given width: MSB only if taken, all bits below MSB if not.
  function automatic word_t weak_cnt(input int unsigned width, input logic taken);
    word_t msb;
    msb = word_t'(1) << (width - 1);
    return taken ? msb : msb - word_t'(1);
  endfunction

endpackage

// File: rtl/sat_counter_update.sv
// Next-state of a saturating up/down direction counter.
module sat_counter_update #(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             taken,
  output logic [CNT_W-1:0] cnt_next
);

  // Step toward the resolved direction, holding at the rails.
  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != '1) cnt_next = cnt + CNT_W'(1);
    end else begin
      if (cnt != '0) cnt_next = cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry direction counters, flush and perf counters.
module branch_target_predictor
  import cpu_types_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  word_t             curr_pc,
  output logic              btb_hit,
  output logic              predict_taken,
  output word_t             bp_pc,
  input  logic              update_en,
  input  word_t             update_pc,
  input  word_t             update_target,
  input  logic              update_taken,
  input  logic              update_mispredict,
  input  logic              flush,
  output logic [PERF_W-1:0] hit_count,
  output logic [PERF_W-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  localparam logic [CNT_W-1:0]  CNT_WEAK_T  = CNT_W'(weak_cnt(CNT_W, 1'b1));
  localparam logic [CNT_W-1:0]  CNT_WEAK_NT = CNT_W'(weak_cnt(CNT_W, 1'b0));
  localparam logic [PERF_W-1:0] PERF_MAX    = '1;

  // Table held as parallel field arrays so flush/reset touch only what they must.
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  word_t             target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic [CNT_W-1:0]  up_cnt_next;

  // Word-aligned PC: low two bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{curr_pc[1:0], update_pc[1:0]};

  assign lk_idx = curr_pc[BTB_TAG_BASE +: IDX_W];
  assign lk_tag = curr_pc[WORD_W-1 -: TAG_W];
  assign up_idx = update_pc[BTB_TAG_BASE +: IDX_W];
  assign up_tag = update_pc[WORD_W-1 -: TAG_W];

  // Fetch-side lookup, zero latency, sees pre-update contents.
  always_comb begin
    btb_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    predict_taken = btb_hit && cnt_q[lk_idx][CNT_W-1];
    bp_pc         = predict_taken ? target_q[lk_idx] : curr_pc + PC_INCR;
  end

  // Update-side hit is judged against the resolved branch's own tag.
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  sat_counter_update #(
    .CNT_W (CNT_W)
  ) u_sat (
    .cnt      (cnt_q[up_idx]),
    .taken    (update_taken),
    .cnt_next (up_cnt_next)
  );

  // Table state: reset, flush (beats update), then resolved-branch writeback.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WEAK_NT;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (update_en) begin
      if (up_hit) begin
        cnt_q[up_idx] <= up_cnt_next;
        if (update_taken) target_q[up_idx] <= update_target;
      end else if (update_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target;
        cnt_q[up_idx]    <= CNT_WEAK_T;
      end
    end
  end

  // Saturating lookup-hit counter; counts regardless of flush.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count <= '0;
    end else if (btb_hit && (hit_count != PERF_MAX)) begin
      hit_count <= hit_count + PERF_W'(1);
    end
  end

  // Saturating reported-mispredict counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mispredict_count <= '0;
    end else if (update_en && update_mispredict && (mispredict_count != PERF_MAX)) begin
      mispredict_count <= mispredict_count + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor with an expected-value scoreboard.
module tb_branch_target_predictor;
  import cpu_types_pkg::*;

  localparam int unsigned PERF_W = 3;
  localparam int          PMAX   = (1 << PERF_W) - 1;
  localparam word_t       MISS   = 32'hFFFF_FFFC;

  logic              clk = 1'b0;
  logic              n_rst;
  word_t             curr_pc;
  logic              btb_hit;
  logic              predict_taken;
  word_t             bp_pc;
  logic              update_en;
  word_t             update_pc;
  word_t             update_target;
  logic              update_taken;
  logic              update_mispredict;
  logic              flush;
  logic [PERF_W-1:0] hit_count;
  logic [PERF_W-1:0] mispredict_count;

  int vectors     = 0;
  int miscompares = 0;
  int exp_hits    = 0;
  int exp_mis     = 0;

  typedef struct {
    int    sel;
    word_t exp;
  } exp_t;

  exp_t  sb[$];
  string names[5] = '{"btb_hit", "predict_taken", "bp_pc", "hit_count", "mispredict_count"};

  always #5 clk = ~clk;

  branch_target_predictor #(
    .ENTRIES (16),
    .CNT_W   (2),
    .PERF_W  (PERF_W)
  ) dut (
    .CLK               (clk),
    .nRST              (n_rst),
    .curr_pc           (curr_pc),
    .btb_hit           (btb_hit),
    .predict_taken     (predict_taken),
    .bp_pc             (bp_pc),
    .update_en         (update_en),
    .update_pc         (update_pc),
    .update_target     (update_target),
    .update_taken      (update_taken),
    .update_mispredict (update_mispredict),
    .flush             (flush),
    .hit_count         (hit_count),
    .mispredict_count  (mispredict_count)
  );

  function automatic word_t observe(input int sel);
    case (sel)
      0:       return word_t'(btb_hit);
      1:       return word_t'(predict_taken);
      2:       return bp_pc;
      3:       return word_t'(hit_count);
      default: return word_t'(mispredict_count);
    endcase
  endfunction

  task automatic expect_outputs(input logic e_hit, input logic e_tk, input word_t e_bp);
    sb.push_back('{0, word_t'(e_hit)});
    sb.push_back('{1, word_t'(e_tk)});
    sb.push_back('{2, e_bp});
    sb.push_back('{3, word_t'(exp_hits)});
    sb.push_back('{4, word_t'(exp_mis)});
  endtask

  task automatic drain(input string step);
    exp_t  e;
    word_t obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s/%s: observed %h expected %h", step, names[e.sel], obs, e.exp);
      end
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model after the edge.
  task automatic cycle(input string step, input word_t pc, input logic e_hit, input logic e_tk,
                       input word_t e_bp, input logic ue, input word_t upc, input word_t utgt,
                       input logic ut, input logic um, input logic fl);
    curr_pc           = pc;
    update_en         = ue;
    update_pc         = upc;
    update_target     = utgt;
    update_taken      = ut;
    update_mispredict = um;
    flush             = fl;
    expect_outputs(e_hit, e_tk, e_bp);
    @(negedge clk);
    drain(step);
    @(posedge clk);
    #1;
    if (e_hit && exp_hits < PMAX) exp_hits++;
    if (ue && um && exp_mis < PMAX) exp_mis++;
    update_en = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic look(input string step, input word_t pc, input logic e_hit, input logic e_tk,
                      input word_t e_bp);
    cycle(step, pc, e_hit, e_tk, e_bp, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic upd(input string step, input word_t upc, input word_t utgt, input logic ut,
                     input logic um);
    cycle(step, MISS, 1'b0, 1'b0, 32'h0, 1'b1, upc, utgt, ut, um, 1'b0);
  endtask

  initial begin
    n_rst             = 1'b0;
    curr_pc           = 32'h40;
    update_en         = 1'b0;
    update_pc         = '0;
    update_target     = '0;
    update_taken      = 1'b0;
    update_mispredict = 1'b0;
    flush             = 1'b0;

    // Outputs while reset is held
    #12;
    expect_outputs(1'b0, 1'b0, 32'h44);
    drain("in_reset");
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    look("post_reset",  32'h40, 1'b0, 1'b0, 32'h44);
    look("miss_wrap",   MISS,   1'b0, 1'b0, 32'h0);
    upd ("install_40",  32'h40, 32'h100, 1'b1, 1'b1);
    look("hit_40",      32'h40, 1'b1, 1'b1, 32'h100);
    upd ("nt_1",        32'h40, 32'h0, 1'b0, 1'b1);
    upd ("nt_2",        32'h40, 32'h0, 1'b0, 1'b0);
    look("cnt_00",      32'h40, 1'b1, 1'b0, 32'h44);
    upd ("t_1",         32'h40, 32'h200, 1'b1, 1'b0);
    look("cnt_01",      32'h40, 1'b1, 1'b0, 32'h44);
    upd ("t_2",         32'h40, 32'h200, 1'b1, 1'b0);
    upd ("t_3",         32'h40, 32'h200, 1'b1, 1'b0);
    upd ("t_4_sat",     32'h40, 32'h200, 1'b1, 1'b0);
    upd ("nt_from_11",  32'h40, 32'h0, 1'b0, 1'b0);
    look("cnt_10",      32'h40, 1'b1, 1'b1, 32'h200);
    upd ("miss_nt",     32'h500, 32'h900, 1'b0, 1'b0);
    look("no_alloc",    32'h40, 1'b1, 1'b1, 32'h200);
    look("no_alloc_500",32'h500, 1'b0, 1'b0, 32'h504);
    upd ("alias_440",   32'h440, 32'h300, 1'b1, 1'b0);
    look("alias_40",    32'h40, 1'b0, 1'b0, 32'h44);
    look("alias_hit",   32'h440, 1'b1, 1'b1, 32'h300);

    // Asynchronous reset mid-cycle, with an update pending across the edge
    #3;
    n_rst             = 1'b0;
    curr_pc           = 32'h440;
    update_en         = 1'b1;
    update_pc         = 32'h40;
    update_target     = 32'h700;
    update_taken      = 1'b1;
    update_mispredict = 1'b1;
    #1;
    exp_hits = 0;
    exp_mis  = 0;
    expect_outputs(1'b0, 1'b0, 32'h444);
    drain("async_reset");
    @(posedge clk);
    #1;
    update_en = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    look ("rst_440",     32'h440, 1'b0, 1'b0, 32'h444);
    look ("rst_40",      32'h40,  1'b0, 1'b0, 32'h44);
    cycle("same_cycle",  32'h80, 1'b0, 1'b0, 32'h84, 1'b1, 32'h80, 32'h180, 1'b1, 1'b0, 1'b0);
    look ("after_same",  32'h80,  1'b1, 1'b1, 32'h180);
    cycle("flush_upd",   MISS, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC0, 32'h1C0, 1'b1, 1'b1, 1'b1);
    look ("flushed_c0",  32'hC0,  1'b0, 1'b0, 32'hC4);
    look ("flushed_80",  32'h80,  1'b0, 1'b0, 32'h84);
    upd  ("reinstall",   32'h80, 32'h180, 1'b1, 1'b0);
    cycle("flush_hit",   32'h80, 1'b1, 1'b1, 32'h180, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    look ("post_flush",  32'h80,  1'b0, 1'b0, 32'h84);
    upd  ("reinstall2",  32'h80, 32'h180, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) look("hit_sat", 32'h80, 1'b1, 1'b1, 32'h180);
    for (int i = 0; i < 7; i++) upd("mis_sat", 32'h1000, 32'h0, 1'b0, 1'b1);
    look ("final",       32'h80,  1'b1, 1'b1, 32'h180);
    look ("final_1000",  32'h1000, 1'b0, 1'b0, 32'h1004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
